// File: rtl/cb_op_sequencer_pkg.sv
// rtl/cb_op_sequencer_pkg.sv - shared states, constants and decode helpers for the CB op sequencer
package cb_op_sequencer_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_MEM_RD,
      ST_EXEC,
      ST_MEM_WR,
      ST_WB
   } state_t;

   // Operand field encodings (opcode[2:0])
   localparam logic [2:0] REG_HL_IND = 3'd6;
   localparam logic [2:0] REG_A      = 3'd7;

   // Operation groups (opcode[7:6])
   localparam logic [1:0] GRP_SHIFT = 2'b00;
   localparam logic [1:0] GRP_BIT   = 2'b01;
   localparam logic [1:0] GRP_RES   = 2'b10;
   localparam logic [1:0] GRP_SET   = 2'b11;

   // Unprefixed accumulator rotates
   localparam logic [7:0] OP_RLCA = 8'h07;
   localparam logic [7:0] OP_RRCA = 8'h0F;
   localparam logic [7:0] OP_RLA  = 8'h17;
   localparam logic [7:0] OP_RRA  = 8'h1F;

   // Cycles a memory request may wait for its acknowledge
   localparam logic [7:0] MEM_TIMEOUT_LIMIT = 8'd255;

   function automatic logic is_acc_rotate(input logic [7:0] op);
      return (op == OP_RLCA) || (op == OP_RRCA) || (op == OP_RLA) || (op == OP_RRA);
   endfunction

   // Only CB-prefixed opcodes can address (HL); unprefixed rotates always use A
   function automatic logic uses_hl(input logic [7:0] op, input logic unprefixed);
      return !unprefixed && (op[2:0] == REG_HL_IND);
   endfunction

   // SET and RES leave the flags untouched
   function automatic logic writes_flags(input logic [1:0] grp);
      logic w;
      w = 1'b0;
      case (grp)
         GRP_SHIFT, GRP_BIT: w = 1'b1;
         GRP_RES, GRP_SET:   w = 1'b0;
      endcase
      return w;
   endfunction

endpackage

// File: rtl/cb_mem_port.sv
// rtl/cb_mem_port.sv - registered memory request port with ack capture; timeout under CB_SEQ_MEM_TIMEOUT_EN
module cb_mem_port (
   input  logic        clk,
   input  logic        rst,
   input  logic        rd_go,
   input  logic        wr_go,
   input  logic [15:0] addr,
   input  logic [7:0]  wdata,
   input  logic        ack,
   input  logic [7:0]  rdata,
   output logic        req,
   output logic        we,
   output logic [15:0] req_addr,
   output logic [7:0]  req_wdata,
   output logic [7:0]  rdata_q,
   output logic        ack_hit,
   output logic        tmo,
   output logic        fault
);

   logic        req_q;
   logic        we_q;
   logic [15:0] addr_q;
   logic [7:0]  wdata_q;
   logic [7:0]  rd_q;

   // An acknowledge only counts while a request is outstanding
   assign ack_hit   = req_q && ack;
   assign req       = req_q;
   assign we        = we_q;
   assign req_addr  = addr_q;
   assign req_wdata = wdata_q;
   assign rdata_q   = rd_q;

   // Request registers: load on go, drop the cycle after ack or on timeout
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         req_q   <= 1'b0;
         we_q    <= 1'b0;
         addr_q  <= 16'h0000;
         wdata_q <= 8'h00;
      end else if (rd_go) begin
         req_q  <= 1'b1;
         we_q   <= 1'b0;
         addr_q <= addr;
      end else if (wr_go) begin
         req_q   <= 1'b1;
         we_q    <= 1'b1;
         addr_q  <= addr;
         wdata_q <= wdata;
      end else if (ack_hit || tmo) begin
         req_q <= 1'b0;
         we_q  <= 1'b0;
      end
   end

   // Capture read data on the acknowledging edge of a read
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_q <= 8'h00;
      end else if (ack_hit && !we_q) begin
         rd_q <= rdata;
      end
   end

`ifdef CB_SEQ_MEM_TIMEOUT_EN
   import cb_op_sequencer_pkg::*;

   logic [7:0] wait_q;
   logic       fault_q;

   assign tmo   = req_q && !ack && (wait_q == (MEM_TIMEOUT_LIMIT - 8'd1));
   assign fault = fault_q;

   // Count unacknowledged request cycles, restarting with each new request
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wait_q <= 8'd0;
      end else if (rd_go || wr_go) begin
         wait_q <= 8'd0;
      end else if (req_q) begin
         wait_q <= wait_q + 8'd1;
      end
   end

   // One-cycle fault pulse following the abandoned request
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fault_q <= 1'b0;
      end else begin
         fault_q <= tmo;
      end
   end
`else
   assign tmo   = 1'b0;
   assign fault = 1'b0;
`endif

endmodule

// File: rtl/cb_op_sequencer.sv
// rtl/cb_op_sequencer.sv - CB/accumulator-rotate sequencer top; memory timeout under CB_SEQ_MEM_TIMEOUT_EN
module cb_op_sequencer (
   input  logic        i_Clk,
   input  logic        i_Reset,
   input  logic        i_Start,
   input  logic [7:0]  i_Opcode,
   input  logic        i_Unprefixed,
   input  logic [15:0] i_HL,
   input  logic [3:0]  i_F,
   output logic [2:0]  o_Reg_Sel,
   input  logic [7:0]  i_Reg_Data,
   output logic        o_Reg_We,
   output logic [7:0]  o_Reg_Wdata,
   output logic        o_F_We,
   output logic [3:0]  o_F,
   output logic [7:0]  o_Alu_A,
   output logic [4:0]  o_Alu_Opcode,
   output logic [3:0]  o_Alu_F,
   output logic        o_Alu_Disable_Z,
   input  logic [7:0]  i_Alu_A,
   input  logic [3:0]  i_Alu_F,
   output logic        o_Mem_Req,
   output logic        o_Mem_We,
   output logic [15:0] o_Mem_Addr,
   output logic [7:0]  o_Mem_Wdata,
   input  logic        i_Mem_Ack,
   input  logic [7:0]  i_Mem_Rdata,
   output logic        o_Busy,
   output logic        o_Done,
   output logic        o_Fault
);
   import cb_op_sequencer_pkg::*;

   state_t      state_q;
   state_t      state_d;
   logic [7:0]  op_q;
   logic        unpref_q;
   logic [15:0] hl_q;
   logic [7:0]  res_q;
   logic [3:0]  flg_q;

   logic        rd_go;
   logic        wr_go;
   logic [7:0]  mem_rdata;
   logic        ack_hit;
   logic        tmo;

   logic        hl_op;
   logic        acc_rot;
   logic        valid_op;
   logic        is_bit;
   logic        reg_op;
   logic [2:0]  reg_sel_cur;

   // Decode of the latched instruction
   assign hl_op       = uses_hl(op_q, unpref_q);
   assign acc_rot     = unpref_q && is_acc_rotate(op_q);
   assign valid_op    = !unpref_q || acc_rot;
   assign is_bit      = (op_q[7:6] == GRP_BIT);
   assign reg_op      = valid_op && !hl_op;
   assign reg_sel_cur = acc_rot ? REG_A : op_q[2:0];

   assign o_Busy      = (state_q != ST_IDLE);
   assign o_Reg_Wdata = res_q;
   assign o_F         = flg_q;

   cb_mem_port u_mem_port (
      .clk       (i_Clk),
      .rst       (i_Reset),
      .rd_go     (rd_go),
      .wr_go     (wr_go),
      .addr      ((state_q == ST_IDLE) ? i_HL : hl_q),
      .wdata     (i_Alu_A),
      .ack       (i_Mem_Ack),
      .rdata     (i_Mem_Rdata),
      .req       (o_Mem_Req),
      .we        (o_Mem_We),
      .req_addr  (o_Mem_Addr),
      .req_wdata (o_Mem_Wdata),
      .rdata_q   (mem_rdata),
      .ack_hit   (ack_hit),
      .tmo       (tmo),
      .fault     (o_Fault)
   );

   // State register
   always_ff @(posedge i_Clk or posedge i_Reset) begin
      if (i_Reset) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Latch the instruction when a start is accepted
   always_ff @(posedge i_Clk or posedge i_Reset) begin
      if (i_Reset) begin
         op_q     <= 8'h00;
         unpref_q <= 1'b0;
         hl_q     <= 16'h0000;
      end else if ((state_q == ST_IDLE) && i_Start) begin
         op_q     <= i_Opcode;
         unpref_q <= i_Unprefixed;
         hl_q     <= i_HL;
      end
   end

   // Hold the logic-unit result for memory write-back and register/flag write
   always_ff @(posedge i_Clk or posedge i_Reset) begin
      if (i_Reset) begin
         res_q <= 8'h00;
         flg_q <= 4'h0;
      end else if (state_q == ST_EXEC) begin
         res_q <= i_Alu_A;
         flg_q <= i_Alu_F;
      end
   end

   // Next state, memory go pulses and per-state outputs
   always_comb begin
      state_d         = state_q;
      rd_go           = 1'b0;
      wr_go           = 1'b0;
      o_Reg_Sel       = 3'd0;
      o_Reg_We        = 1'b0;
      o_F_We          = 1'b0;
      o_Alu_A         = 8'h00;
      o_Alu_Opcode    = 5'd0;
      o_Alu_F         = 4'h0;
      o_Alu_Disable_Z = 1'b0;
      o_Done          = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (i_Start) begin
               if (uses_hl(i_Opcode, i_Unprefixed)) begin
                  state_d = ST_MEM_RD;
                  rd_go   = 1'b1;
               end else begin
                  state_d = ST_EXEC;
               end
            end
         end
         ST_MEM_RD: begin
            if (tmo) begin
               state_d = ST_IDLE;
            end else if (ack_hit) begin
               state_d = ST_EXEC;
            end
         end
         ST_EXEC: begin
            if (reg_op) begin
               o_Reg_Sel = reg_sel_cur;
            end
            o_Alu_A         = hl_op ? mem_rdata : i_Reg_Data;
            o_Alu_Opcode    = op_q[7:3];
            o_Alu_F         = i_F;
            o_Alu_Disable_Z = acc_rot;
            if (hl_op && !is_bit) begin
               state_d = ST_MEM_WR;
               wr_go   = 1'b1;
            end else begin
               state_d = ST_WB;
            end
         end
         ST_MEM_WR: begin
            if (tmo) begin
               state_d = ST_IDLE;
            end else if (ack_hit) begin
               state_d = ST_WB;
            end
         end
         ST_WB: begin
            o_Done = 1'b1;
            if (reg_op) begin
               o_Reg_Sel = reg_sel_cur;
            end
            o_Reg_We = reg_op && !is_bit;
            o_F_We   = valid_op && writes_flags(op_q[7:6]);
            state_d  = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

endmodule

// File: tb/tb_cb_op_sequencer.sv
// tb/tb_cb_op_sequencer.sv - scoreboard bench for cb_op_sequencer; timeout case under CB_SEQ_MEM_TIMEOUT_EN
module tb_cb_op_sequencer;

   logic        i_Clk;
   logic        i_Reset;
   logic        i_Start;
   logic [7:0]  i_Opcode;
   logic        i_Unprefixed;
   logic [15:0] i_HL;
   logic [3:0]  i_F;
   logic [2:0]  o_Reg_Sel;
   logic [7:0]  i_Reg_Data;
   logic        o_Reg_We;
   logic [7:0]  o_Reg_Wdata;
   logic        o_F_We;
   logic [3:0]  o_F;
   logic [7:0]  o_Alu_A;
   logic [4:0]  o_Alu_Opcode;
   logic [3:0]  o_Alu_F;
   logic        o_Alu_Disable_Z;
   logic [7:0]  i_Alu_A;
   logic [3:0]  i_Alu_F;
   logic        o_Mem_Req;
   logic        o_Mem_We;
   logic [15:0] o_Mem_Addr;
   logic [7:0]  o_Mem_Wdata;
   logic        i_Mem_Ack;
   logic [7:0]  i_Mem_Rdata;
   logic        o_Busy;
   logic        o_Done;
   logic        o_Fault;

   typedef struct {
      logic       valid;
      int         due;
      logic       reg_we;
      logic [2:0] sel;
      logic [7:0] wdata;
      logic       f_we;
      logic [3:0] f;
   } exp_t;

   typedef struct {
      logic [15:0] addr;
      logic        we;
      logic [7:0]  wdata;
   } mexp_t;

   exp_t  exp_q[$];
   mexp_t mem_q[$];

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int rd_delay = 1;
   int wr_delay = 1;
   logic [7:0] mem_byte = 8'h00;
   logic       fault_ok = 1'b0;
   logic [7:0] regs [0:7];

   cb_op_sequencer dut (
      .i_Clk           (i_Clk),
      .i_Reset         (i_Reset),
      .i_Start         (i_Start),
      .i_Opcode        (i_Opcode),
      .i_Unprefixed    (i_Unprefixed),
      .i_HL            (i_HL),
      .i_F             (i_F),
      .o_Reg_Sel       (o_Reg_Sel),
      .i_Reg_Data      (i_Reg_Data),
      .o_Reg_We        (o_Reg_We),
      .o_Reg_Wdata     (o_Reg_Wdata),
      .o_F_We          (o_F_We),
      .o_F             (o_F),
      .o_Alu_A         (o_Alu_A),
      .o_Alu_Opcode    (o_Alu_Opcode),
      .o_Alu_F         (o_Alu_F),
      .o_Alu_Disable_Z (o_Alu_Disable_Z),
      .i_Alu_A         (i_Alu_A),
      .i_Alu_F         (i_Alu_F),
      .o_Mem_Req       (o_Mem_Req),
      .o_Mem_We        (o_Mem_We),
      .o_Mem_Addr      (o_Mem_Addr),
      .o_Mem_Wdata     (o_Mem_Wdata),
      .i_Mem_Ack       (i_Mem_Ack),
      .i_Mem_Rdata     (i_Mem_Rdata),
      .o_Busy          (o_Busy),
      .o_Done          (o_Done),
      .o_Fault         (o_Fault)
   );

   // External bit/shift/rotate logic unit
   function automatic logic [11:0] alu(input logic [7:0] a, input logic [4:0] op,
                                       input logic [3:0] f, input logic dz);
      logic [7:0] r;
      logic       c;
      logic [3:0] nf;
      r  = a;
      c  = f[0];
      nf = f;
      case (op[4:3])
         2'b00: begin
            case (op[2:0])
               3'd0: begin c = a[7]; r = {a[6:0], a[7]}; end
               3'd1: begin c = a[0]; r = {a[0], a[7:1]}; end
               3'd2: begin c = a[7]; r = {a[6:0], f[0]}; end
               3'd3: begin c = a[0]; r = {f[0], a[7:1]}; end
               3'd4: begin c = a[7]; r = {a[6:0], 1'b0}; end
               3'd5: begin c = a[0]; r = {a[7], a[7:1]}; end
               3'd6: begin c = 1'b0; r = {a[3:0], a[7:4]}; end
               default: begin c = a[0]; r = {1'b0, a[7:1]}; end
            endcase
            nf = {(r == 8'h00) && !dz, 1'b0, 1'b0, c};
         end
         2'b01:   nf = {~a[op[2:0]], 1'b0, 1'b1, f[0]};
         2'b10:   r = a & ~(8'd1 << op[2:0]);
         default: r = a | (8'd1 << op[2:0]);
      endcase
      return {r, nf};
   endfunction

   assign {i_Alu_A, i_Alu_F} = alu(o_Alu_A, o_Alu_Opcode, o_Alu_F, o_Alu_Disable_Z);
   assign i_Reg_Data = regs[o_Reg_Sel];

   initial i_Clk = 1'b0;
   always #5 i_Clk = ~i_Clk;
   always @(posedge i_Clk) cyc <= cyc + 1;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic exp_t mk(input logic we, input logic [2:0] sel, input logic [7:0] wd,
                               input logic fwe, input logic [3:0] f);
      exp_t e;
      e.valid  = 1'b1;
      e.due    = 0;
      e.reg_we = we;
      e.sel    = sel;
      e.wdata  = wd;
      e.f_we   = fwe;
      e.f      = f;
      return e;
   endfunction

   // Memory responder and request checker
   initial begin
      int wcnt;
      mexp_t m;
      wcnt = 0;
      i_Mem_Ack = 1'b0;
      i_Mem_Rdata = 8'h00;
      forever begin
         @(negedge i_Clk);
         if (o_Mem_Req) begin
            wcnt++;
            if (wcnt == (o_Mem_We ? wr_delay : rd_delay)) begin
               i_Mem_Ack = 1'b1;
               i_Mem_Rdata = mem_byte;
               if (mem_q.size() == 0) begin
                  chk("mem_unexpected_req", 32'(o_Mem_Req), 32'd0);
               end else begin
                  m = mem_q.pop_front();
                  chk("mem_addr", 32'(o_Mem_Addr), 32'(m.addr));
                  chk("mem_we", 32'(o_Mem_We), 32'(m.we));
                  if (m.we) chk("mem_wdata", 32'(o_Mem_Wdata), 32'(m.wdata));
               end
            end else begin
               i_Mem_Ack = 1'b0;
            end
         end else begin
            wcnt = 0;
            i_Mem_Ack = 1'b0;
         end
      end
   end

   // Completion monitor
   initial begin
      exp_t e;
      forever begin
         @(negedge i_Clk);
         if (o_Fault && !fault_ok) chk("fault_unexpected", 32'(o_Fault), 32'd0);
         if (o_Done) begin
            if (exp_q.size() == 0) begin
               chk("done_unexpected", 32'(o_Done), 32'd0);
            end else begin
               e = exp_q.pop_front();
               chk("done_cycle", 32'(cyc), 32'(e.due));
               chk("reg_we", 32'(o_Reg_We), 32'(e.reg_we));
               chk("f_we", 32'(o_F_We), 32'(e.f_we));
               if (e.reg_we) begin
                  chk("reg_sel", 32'(o_Reg_Sel), 32'(e.sel));
                  chk("reg_wdata", 32'(o_Reg_Wdata), 32'(e.wdata));
               end
               if (e.f_we) chk("flags", 32'(o_F), 32'(e.f));
            end
         end
      end
   end

   task automatic issue(input logic [7:0] op, input logic unp, input logic [15:0] hl,
                        input logic [3:0] f, input exp_t e, input int lat);
      exp_t x;
      x = e;
      i_Opcode     = op;
      i_Unprefixed = unp;
      i_HL         = hl;
      i_F          = f;
      i_Start      = 1'b1;
      x.due        = cyc + lat;
      if (x.valid) exp_q.push_back(x);
      @(posedge i_Clk);
      #1 i_Start = 1'b0;
   endtask

   task automatic wait_idle(input int budget);
      int n;
      n = 0;
      do begin
         @(negedge i_Clk);
         n++;
      end while ((o_Busy || exp_q.size() != 0 || mem_q.size() != 0) && n < budget);
      chk("drain_idle", 32'(o_Busy || exp_q.size() != 0 || mem_q.size() != 0), 32'd0);
   endtask

   initial begin
      exp_t none;
      int n;
      int s;
      none = mk(1'b0, 3'd0, 8'h00, 1'b0, 4'h0);
      none.valid = 1'b0;
      for (int i = 0; i < 8; i++) regs[i] = 8'h00;
      i_Reset = 1'b1;
      i_Start = 1'b0;
      i_Opcode = 8'h00;
      i_Unprefixed = 1'b0;
      i_HL = 16'h0000;
      i_F = 4'h0;

      // reset state
      @(negedge i_Clk);
      @(negedge i_Clk);
      chk("rst_busy", 32'(o_Busy), 32'd0);
      chk("rst_done", 32'(o_Done), 32'd0);
      chk("rst_fault", 32'(o_Fault), 32'd0);
      chk("rst_req", 32'(o_Mem_Req), 32'd0);
      chk("rst_mem_we", 32'(o_Mem_We), 32'd0);
      chk("rst_addr", 32'(o_Mem_Addr), 32'd0);
      chk("rst_sel", 32'(o_Reg_Sel), 32'd0);
      chk("rst_reg_we", 32'(o_Reg_We), 32'd0);
      chk("rst_f_we", 32'(o_F_We), 32'd0);
      i_Reset = 1'b0;
      @(negedge i_Clk);

      // SWAP B, B=A5
      regs[0] = 8'hA5;
      issue(8'h30, 1'b0, 16'h0000, 4'h0, mk(1'b1, 3'd0, 8'h5A, 1'b1, 4'b0000), 2);
      wait_idle(50);

      // RLC (HL), HL=C000, mem=80, 3-cycle waits
      mem_byte = 8'h80; rd_delay = 3; wr_delay = 3;
      mem_q.push_back('{16'hC000, 1'b0, 8'h00});
      mem_q.push_back('{16'hC000, 1'b1, 8'h01});
      issue(8'h06, 1'b0, 16'hC000, 4'h0, mk(1'b0, 3'd0, 8'h00, 1'b1, 4'b0001), 8);
      wait_idle(50);

      // BIT 7,(HL), mem=00, F=0001
      mem_byte = 8'h00; rd_delay = 1; wr_delay = 1;
      mem_q.push_back('{16'h1234, 1'b0, 8'h00});
      issue(8'h7E, 1'b0, 16'h1234, 4'b0001, mk(1'b0, 3'd0, 8'h00, 1'b1, 4'b1011), 3);
      wait_idle(50);

      // RLA, A=80
      regs[7] = 8'h80;
      issue(8'h17, 1'b1, 16'h0000, 4'b0000, mk(1'b1, 3'd7, 8'h00, 1'b1, 4'b0001), 2);
      wait_idle(50);

      // SET 3,C with start repeated while busy
      regs[1] = 8'h00;
      issue(8'hD9, 1'b0, 16'h0000, 4'b0001, mk(1'b1, 3'd1, 8'h08, 1'b0, 4'h0), 2);
      @(negedge i_Clk);
      i_Opcode = 8'h30;
      i_Start = 1'b1;
      @(negedge i_Clk);
      i_Start = 1'b0;
      wait_idle(50);

      // RES 0,(HL), mem=FF, waits 2/1
      mem_byte = 8'hFF; rd_delay = 2; wr_delay = 1;
      mem_q.push_back('{16'h8001, 1'b0, 8'h00});
      mem_q.push_back('{16'h8001, 1'b1, 8'hFE});
      issue(8'h86, 1'b0, 16'h8001, 4'b1010, mk(1'b0, 3'd0, 8'h00, 1'b0, 4'h0), 5);
      wait_idle(50);

      // unprefixed non-rotate: done only
      issue(8'h00, 1'b1, 16'h0000, 4'b1111, mk(1'b0, 3'd0, 8'h00, 1'b0, 4'h0), 2);
      wait_idle(50);

      // RRCA, A=01
      regs[7] = 8'h01;
      issue(8'h0F, 1'b1, 16'h0000, 4'b0000, mk(1'b1, 3'd7, 8'h80, 1'b1, 4'b0001), 2);
      wait_idle(50);

      // SRL E, E=01 (Z not suppressed)
      regs[3] = 8'h01;
      issue(8'h3B, 1'b0, 16'h0000, 4'b0000, mk(1'b1, 3'd3, 8'h00, 1'b1, 4'b1001), 2);
      wait_idle(50);

      // reset asserted during MEM_WR
      mem_byte = 8'h80; rd_delay = 1; wr_delay = 100000;
      mem_q.push_back('{16'h4000, 1'b0, 8'h00});
      issue(8'h06, 1'b0, 16'h4000, 4'h0, none, 0);
      n = 0;
      while (!(o_Mem_Req && o_Mem_We) && n < 50) begin
         @(negedge i_Clk);
         n++;
      end
      chk("rst_reach_wr", 32'(o_Mem_Req && o_Mem_We), 32'd1);
      #2 i_Reset = 1'b1;
      #1;
      chk("midrst_req", 32'(o_Mem_Req), 32'd0);
      chk("midrst_busy", 32'(o_Busy), 32'd0);
      chk("midrst_done", 32'(o_Done), 32'd0);
      chk("midrst_reg_we", 32'(o_Reg_We), 32'd0);
      chk("midrst_f_we", 32'(o_F_We), 32'd0);
      @(negedge i_Clk);
      i_Reset = 1'b0;
      wr_delay = 1;
      wait_idle(20);

`ifdef CB_SEQ_MEM_TIMEOUT_EN
      // no acknowledge: fault after 255 waiting cycles
      rd_delay = 100000;
      fault_ok = 1'b1;
      s = cyc;
      issue(8'h06, 1'b0, 16'h2000, 4'h0, none, 0);
      n = 0;
      while (!o_Fault && n < 400) begin
         @(negedge i_Clk);
         n++;
      end
      chk("tmo_cycle", 32'(cyc), 32'(s + 256));
      chk("tmo_fault", 32'(o_Fault), 32'd1);
      chk("tmo_req", 32'(o_Mem_Req), 32'd0);
      chk("tmo_busy", 32'(o_Busy), 32'd0);
      chk("tmo_done", 32'(o_Done), 32'd0);
      @(negedge i_Clk);
      fault_ok = 1'b0;
      rd_delay = 1;
      wait_idle(20);
`else
      s = 0;
`endif

      // recovery: SWAP B, B=3C
      regs[0] = 8'h3C;
      issue(8'h30, 1'b0, 16'h0000, 4'h0, mk(1'b1, 3'd0, 8'hC3, 1'b1, 4'b0000), 2 + s - s);
      wait_idle(50);

      chk("exp_q_empty", 32'(exp_q.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
